// File: rtl/skid_rr_arbiter.sv
// skid_rr_arbiter: round-robin burst arbiter feeding one valid/ready stream through a two-entry registered skid stage
module skid_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
  localparam int SW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      e_ready_i,
  output logic                      e_valid_o,
  output logic [DATA_W-1:0]         e_data_o,
  output logic [SW-1:0]             e_src_o,
  output logic                      busy_o
);
  typedef enum logic {ARB, GRANT} state_t;
  state_t state, state_n;
  logic [SW-1:0] ptr, g, pick, out_s, skid_s;
  logic [3:0] cnt;
  logic out_v, skid_v, accept, rel, drain;
  logic [DATA_W-1:0] out_d, skid_d, beat;
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid_i[(int'(ptr) + i) % NUM_REQ]) pick = SW'((int'(ptr) + i) % NUM_REQ);
  end
  assign beat   = req_data_i[int'(g)*DATA_W +: DATA_W];
  // ready comes only from registered skid_v, keeping e_ready_i off every ready path
  assign accept = state == GRANT && !skid_v && req_valid_i[g];
  assign rel    = state == GRANT && (!req_valid_i[g] || (accept && cnt == 4'(BURST_MAX - 1)));
  assign drain  = out_v & e_ready_i;
  always_ff @(posedge clk)
    if (reset) state <= ARB;
    else state <= state_n;
  always_comb begin
    state_n = state == ARB ? (|req_valid_i ? GRANT : ARB) : (rel ? ARB : GRANT);
  end
  always_comb begin
    busy_o      = state == GRANT;
    req_ready_o = (state == GRANT && !skid_v) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << g : '0;
    e_valid_o   = out_v;
    e_data_o    = out_d;
    e_src_o     = out_s;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      g      <= '0;
      cnt    <= '0;
      out_v  <= 1'b0;
      out_d  <= '0;
      out_s  <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
      skid_s <= '0;
    end else begin
      if (state == ARB && |req_valid_i) begin
        g   <= pick;
        cnt <= '0;
      end
      if (accept) cnt <= cnt + 4'd1;
      if (rel) ptr <= (g == SW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
      // skid always holds the older beat, so it is promoted before any new one
      if (accept && (!out_v || drain)) begin
        out_v <= 1'b1;
        out_d <= skid_v ? skid_d : beat;
        out_s <= skid_v ? skid_s : g;
        if (skid_v) begin
          skid_d <= beat;
          skid_s <= g;
        end
      end else if (accept) begin
        skid_v <= 1'b1;
        skid_d <= beat;
        skid_s <= g;
      end else if (drain) begin
        if (skid_v) begin
          out_d  <= skid_d;
          out_s  <= skid_s;
          skid_v <= 1'b0;
        end else out_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_skid_rr_arbiter.sv
// tb_skid_rr_arbiter: directed and random checks of skid_rr_arbiter against per-source queues and an in-order scoreboard
module tb_skid_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int BM = 4;
  // waiting also covers the arbitration cycle that precedes the requester's own grant
  localparam int STARVE_MAX = (N - 1) * (BM + 1) + 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid_i = '0;
  logic [N*W-1:0] req_data_i = '0;
  logic [N-1:0] req_ready_o;
  logic e_ready_i = 1'b1;
  logic e_valid_o;
  logic [W-1:0] e_data_o;
  logic [1:0] e_src_o;
  logic busy_o;
  int checks = 0;
  int failures = 0;
  logic [7:0] q [N][$];
  logic [9:0] exp_q [$];
  logic [N-1:0] en = '0;
  logic mon = 1'b0;
  int w [N];
  int maxw = 0;
  skid_rr_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .e_ready_i(e_ready_i), .e_valid_o(e_valid_o),
    .e_data_o(e_data_o), .e_src_o(e_src_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid_i[k] = en[k] && q[k].size() != 0;
      req_data_i[k*W +: W] = q[k].size() != 0 ? q[k][0] : 8'h00;
    end
  endtask
  task automatic tick();
    logic [N-1:0] acc;
    logic dv, rs;
    logic [9:0] db;
    acc = req_ready_o & req_valid_i;
    dv = e_valid_o & e_ready_i;
    db = {e_src_o, e_data_o};
    rs = reset;
    for (int k = 0; k < N; k++)
      if (mon && req_valid_i[k]) begin
        w[k] = req_ready_o[k] ? 0 : w[k] + 1;
        if (w[k] > maxw) maxw = w[k];
      end
    @(posedge clk);
    @(negedge clk);
    if (!rs) begin
      for (int k = 0; k < N; k++)
        if (acc[k]) begin
          exp_q.push_back({2'(k), q[k][0]});
          void'(q[k].pop_front());
        end
      if (dv) begin
        if (exp_q.size() == 0) chk("sb_extra_beat", {22'd0, db}, 32'hffff_ffff);
        else chk("sb_order", {22'd0, db}, {22'd0, exp_q.pop_front()});
      end
    end
    drive();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    en = '0;
    for (int k = 0; k < N; k++) q[k].delete();
    exp_q.delete();
    drive();
    tick();
    tick();
    reset = 1'b0;
    en = '1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_ready", {28'd0, req_ready_o}, 0);
    chk("rst_valid", {31'd0, e_valid_o}, 0);
    chk("rst_data", {24'd0, e_data_o}, 0);
    chk("rst_src", {30'd0, e_src_o}, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    // single requester streams A0..A2
    q[2] = '{8'hA0, 8'hA1, 8'hA2};
    drive();
    chk("t1_arb_ready", {28'd0, req_ready_o}, 0);
    tick();
    chk("t1_busy", {31'd0, busy_o}, 1);
    chk("t1_ready", {28'd0, req_ready_o}, 4'b0100);
    chk("t1_novalid", {31'd0, e_valid_o}, 0);
    tick();
    chk("t1_b0", {21'd0, e_valid_o, e_src_o, e_data_o}, {21'd0, 1'b1, 2'd2, 8'hA0});
    tick();
    chk("t1_b1", {21'd0, e_valid_o, e_src_o, e_data_o}, {21'd0, 1'b1, 2'd2, 8'hA1});
    tick();
    chk("t1_b2", {21'd0, e_valid_o, e_src_o, e_data_o}, {21'd0, 1'b1, 2'd2, 8'hA2});
    tick();
    chk("t1_release", {31'd0, busy_o}, 0);
    chk("t1_empty", {31'd0, e_valid_o}, 0);
    chk("t1_hold", {24'd0, e_data_o}, 8'hA2);
    // all four requesters: bursts of four, one bubble per grant
    do_reset();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 8; i++) q[k].push_back(8'(k * 16 + i));
    drive();
    for (int n = 1; n <= 25; n++) begin
      tick();
      if ((n - 1) % 5 == 0) chk($sformatf("t2_bubble%0d", n), {31'd0, e_valid_o}, 0);
      else chk($sformatf("t2_beat%0d", n), {21'd0, e_valid_o, e_src_o, e_data_o},
               {21'd0, 1'b1, 2'(((n - 2) / 5) % 4), 8'((((n - 2) / 5) % 4) * 16 + ((n - 2) / 5 / 4) * 4 + (n - 2) % 5)});
    end
    // backpressure fills out and skid, then drains in order
    do_reset();
    e_ready_i = 1'b0;
    q[1] = '{8'h11, 8'h12, 8'h13};
    drive();
    tick();
    chk("t3_ready", {28'd0, req_ready_o}, 4'b0010);
    tick();
    chk("t3_out11", {21'd0, e_valid_o, e_src_o, e_data_o}, {21'd0, 1'b1, 2'd1, 8'h11});
    tick();
    chk("t3_skid_full", {28'd0, req_ready_o}, 0);
    tick();
    chk("t3_stall_ready", {28'd0, req_ready_o}, 0);
    chk("t3_stall_data", {24'd0, e_data_o}, 8'h11);
    e_ready_i = 1'b1;
    tick();
    chk("t3_out12", {24'd0, e_data_o}, 8'h12);
    chk("t3_ready_back", {28'd0, req_ready_o}, 4'b0010);
    tick();
    chk("t3_out13", {24'd0, e_data_o}, 8'h13);
    tick();
    chk("t3_done", {30'd0, busy_o, e_valid_o}, 0);
    chk("t3_sb_empty", exp_q.size(), 0);
    // granted requester drops valid early; pointer wraps to 0
    do_reset();
    q[2] = '{8'h20};
    drive();
    ticks(2);
    q[3] = '{8'h30, 8'h31};
    q[0] = '{8'h40};
    drive();
    tick();
    chk("t4_rel2", {31'd0, busy_o}, 0);
    tick();
    chk("t4_grant3", {28'd0, req_ready_o}, 4'b1000);
    tick();
    chk("t4_b30", {21'd0, e_valid_o, e_src_o, e_data_o}, {21'd0, 1'b1, 2'd3, 8'h30});
    tick();
    chk("t4_b31", {24'd0, e_data_o}, 8'h31);
    tick();
    chk("t4_rel3", {31'd0, busy_o}, 0);
    tick();
    chk("t4_grant0", {28'd0, req_ready_o}, 4'b0001);
    tick();
    chk("t4_b40", {21'd0, e_valid_o, e_src_o, e_data_o}, {21'd0, 1'b1, 2'd0, 8'h40});
    // reset with both output entries full
    do_reset();
    e_ready_i = 1'b0;
    q[2] = '{8'h50, 8'h51, 8'h52};
    drive();
    ticks(3);
    chk("t5_full_valid", {31'd0, e_valid_o}, 1);
    chk("t5_full_ready", {28'd0, req_ready_o}, 0);
    q[1] = '{8'h60};
    q[3] = '{8'h70};
    reset = 1'b1;
    drive();
    tick();
    exp_q.delete();
    chk("t5_rst_valid", {31'd0, e_valid_o}, 0);
    chk("t5_rst_ready", {28'd0, req_ready_o}, 0);
    chk("t5_rst_busy", {31'd0, busy_o}, 0);
    reset = 1'b0;
    e_ready_i = 1'b1;
    tick();
    chk("t5_lowest", {28'd0, req_ready_o}, 4'b0010);
    tick();
    chk("t5_b60", {21'd0, e_valid_o, e_src_o, e_data_o}, {21'd0, 1'b1, 2'd1, 8'h60});
    // random valid/ready traffic against the scoreboard
    do_reset();
    for (int c = 0; c < 8000; c++) begin
      e_ready_i = $urandom_range(0, 3) != 0;
      for (int k = 0; k < N; k++) begin
        if (q[k].size() < 3) q[k].push_back(8'($urandom));
        en[k] = $urandom_range(0, 3) != 0;
      end
      drive();
      tick();
    end
    // saturated load with an always-ready sink for the starvation bound
    do_reset();
    e_ready_i = 1'b1;
    for (int k = 0; k < N; k++) w[k] = 0;
    mon = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < N; k++) if (q[k].size() < 3) q[k].push_back(8'($urandom));
      drive();
      tick();
    end
    mon = 1'b0;
    chk("starve_bound", {31'd0, maxw <= STARVE_MAX}, 1);
    en = '0;
    drive();
    ticks(8);
    chk("final_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
